// File: rtl/memory_pkg.sv
// Shared constants and types for the unified 64 KB memory system.
// IMEM occupies the low 16 KB; DMEM follows directly above it.
package memory_pkg;

    localparam int MEM_ADDR_WIDTH = 32;
    localparam int MEM_WORD_WIDTH = 32;
    localparam int MEM_BYTES      = 32'h0001_0000;
    localparam int IMEM_BYTES     = 32'h0000_4000;
    localparam int IMEM_BASE      = 0;
    localparam int DMEM_BASE      = IMEM_BYTES;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        WORD     = 2'b00,
        BYTE     = 2'b01,
        HALF     = 2'b10,
        RESERVED = 2'b11
    } e_num_bytes;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_DM = 1'b1
    } e_port_id;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the core's right-aligned data and the memory word.
// Store side builds byte enables and replicated write data; load side extracts and extends.
module mem_lane_align
    import memory_pkg::*;
#(
    parameter int DATA_W = MEM_WORD_WIDTH
) (
    input  e_num_bytes        st_size,
    input  logic [1:0]        st_lane,
    input  logic [DATA_W-1:0] st_wdata,
    output logic [3:0]        st_be,
    output logic [DATA_W-1:0] st_wdata_rep,
    input  e_num_bytes        ld_size,
    input  logic [1:0]        ld_lane,
    input  logic              ld_unsigned,
    input  logic [DATA_W-1:0] ld_rdata,
    output logic [DATA_W-1:0] ld_data
);

    logic [DATA_W-1:0] shifted;

    // Replicating the store data lets the memory pick whichever lane the enables select.
    always_comb begin
        st_be        = 4'b0000;
        st_wdata_rep = st_wdata;
        case (st_size)
            WORD: st_be = 4'b1111;
            HALF: begin
                st_be        = 4'b0011 << st_lane;
                st_wdata_rep = {(DATA_W/16){st_wdata[15:0]}};
            end
            BYTE: begin
                st_be        = 4'b0001 << st_lane;
                st_wdata_rep = {(DATA_W/8){st_wdata[7:0]}};
            end
            default: st_be = 4'b0000;
        endcase
    end

    assign shifted = ld_rdata >> {ld_lane, 3'b000};

    always_comb begin
        ld_data = ld_rdata;
        case (ld_size)
            HALF: ld_data = {{(DATA_W-16){~ld_unsigned & shifted[15]}}, shifted[15:0]};
            BYTE: ld_data = {{(DATA_W-8){~ld_unsigned & shifted[7]}}, shifted[7:0]};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single-port unified memory: data port has priority,
// fetch is protected from starvation, and every grant gets a response exactly one cycle later.
module mem_arbiter
    import memory_pkg::*;
#(
    parameter int ADDR_W        = MEM_ADDR_WIDTH,
    parameter int DATA_W        = MEM_WORD_WIDTH,
    parameter int STARVE_MAX    = STARVE_MAX_DEF,
    parameter bit ALLOW_IMEM_WR = 1'b0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [1:0]        dm_n_bytes,
    input  logic              dm_unsigned,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [13:0]       mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    e_num_bytes        dm_size;
    logic [CNT_W-1:0]  starve_cnt;
    logic              grant_if;
    logic              grant_dm;
    logic              if_bad;
    logic              dm_bad;
    logic              req_bad;
    logic [3:0]        dm_be;
    logic [DATA_W-1:0] dm_wdata_rep;
    logic [DATA_W-1:0] ld_data;

    logic              rsp_valid;
    e_port_id          rsp_port;
    logic [1:0]        rsp_lane;
    e_num_bytes        rsp_size;
    logic              rsp_unsigned;
    logic              rsp_we;
    logic              rsp_err;

    assign dm_size = e_num_bytes'(dm_n_bytes);

    // Grants are masked while reset is held so every output reads 0 during reset.
    assign grant_if = rstn && if_req && (!dm_req || starve_cnt == CNT_MAX);
    assign grant_dm = rstn && dm_req && !grant_if;
    assign if_gnt   = grant_if;
    assign dm_gnt   = grant_dm;

    assign if_bad = (if_addr >= ADDR_W'(IMEM_BYTES)) || (if_addr[1:0] != 2'b00);

    always_comb begin
        dm_bad = dm_addr >= ADDR_W'(MEM_BYTES);
        case (dm_size)
            WORD:     if (dm_addr[1:0] != 2'b00) dm_bad = 1'b1;
            HALF:     if (dm_addr[0]) dm_bad = 1'b1;
            RESERVED: dm_bad = 1'b1;
            default:  ;
        endcase
        if (dm_we && !ALLOW_IMEM_WR && dm_addr < ADDR_W'(IMEM_BYTES)) dm_bad = 1'b1;
    end

    assign req_bad = grant_if ? if_bad : dm_bad;

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .st_size      (dm_size),
        .st_lane      (dm_addr[1:0]),
        .st_wdata     (dm_wdata),
        .st_be        (dm_be),
        .st_wdata_rep (dm_wdata_rep),
        .ld_size      (rsp_size),
        .ld_lane      (rsp_lane),
        .ld_unsigned  (rsp_unsigned),
        .ld_rdata     (mem_rdata),
        .ld_data      (ld_data)
    );

    // Erroneous requests are still granted but never reach the memory.
    always_comb begin
        mem_en    = (grant_if || grant_dm) && !req_bad;
        mem_we    = mem_en && grant_dm && dm_we;
        mem_addr  = 14'h0000;
        mem_be    = 4'b0000;
        mem_wdata = '0;
        if (mem_en) begin
            mem_addr = grant_if ? if_addr[15:2] : dm_addr[15:2];
            mem_be   = grant_if ? 4'b1111 : dm_be;
        end
        if (mem_we) mem_wdata = dm_wdata_rep;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (if_req && grant_dm && starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Response context captured at grant so the returning word can be steered next cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid    <= 1'b0;
            rsp_port     <= PORT_IF;
            rsp_lane     <= 2'b00;
            rsp_size     <= WORD;
            rsp_unsigned <= 1'b0;
            rsp_we       <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            rsp_valid    <= grant_if || grant_dm;
            rsp_port     <= grant_dm ? PORT_DM : PORT_IF;
            rsp_lane     <= grant_dm ? dm_addr[1:0] : 2'b00;
            rsp_size     <= grant_dm ? dm_size : WORD;
            rsp_unsigned <= grant_dm && dm_unsigned;
            rsp_we       <= grant_dm && dm_we;
            rsp_err      <= (grant_if || grant_dm) && req_bad;
        end
    end

    assign if_rvalid = rsp_valid && rsp_port == PORT_IF;
    assign dm_rvalid = rsp_valid && rsp_port == PORT_DM;
    assign if_err    = if_rvalid && rsp_err;
    assign dm_err    = dm_rvalid && rsp_err;
    assign if_rdata  = (if_rvalid && !rsp_err) ? mem_rdata : '0;
    assign dm_rdata  = (dm_rvalid && !rsp_err && !rsp_we) ? ld_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases plus randomized two-port traffic
// checked against a byte-level memory and arbitration model.
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk;
    logic        rstn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [1:0]  dm_n_bytes;
    logic        dm_unsigned;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        dm_err;
    logic        mem_en;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        use_model;
    logic        init_mem;
    logic [31:0] forced_rdata;
    logic [31:0] model_rdata;
    logic [31:0] macro_mem [16384];
    logic [31:0] ref_mem   [16384];
    logic [121:0] all_outs;

    int n_cmp;
    int n_fail;

    mem_arbiter #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .STARVE_MAX    (STARVE_MAX),
        .ALLOW_IMEM_WR (1'b0)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_gnt      (if_gnt),
        .if_rvalid   (if_rvalid),
        .if_rdata    (if_rdata),
        .if_err      (if_err),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_n_bytes  (dm_n_bytes),
        .dm_unsigned (dm_unsigned),
        .dm_gnt      (dm_gnt),
        .dm_rvalid   (dm_rvalid),
        .dm_rdata    (dm_rdata),
        .dm_err      (dm_err),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = use_model ? model_rdata : forced_rdata;
    assign all_outs  = {if_gnt, if_rvalid, if_rdata, if_err, dm_gnt, dm_rvalid, dm_rdata, dm_err,
                        mem_en, mem_we, mem_addr, mem_be, mem_wdata};

    function automatic logic [31:0] seed_word(input int i);
        return {i[15:0] ^ 16'hA5C3, ~i[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Memory macro: one-cycle read latency, byte-enabled writes.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 16384; i++) macro_mem[i] <= seed_word(i);
        end else if (mem_en) begin
            model_rdata <= macro_mem[mem_addr];
            if (mem_we)
                for (int k = 0; k < 4; k++)
                    if (mem_be[k]) macro_mem[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
        end
    end

    task automatic drive_idle();
        if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0;
        dm_wdata = 0; dm_n_bytes = 0; dm_unsigned = 0;
    endtask

    task automatic do_reset();
        rstn = 0;
        drive_idle();
        repeat (2) @(negedge clk);
        rstn = 1;
    endtask

    task automatic test_reset();
        rstn = 0;
        if_req = 1; if_addr = 32'h10; dm_req = 1; dm_addr = 32'h4000;
        forced_rdata = 32'hFFFF_FFFF;
        #1;
        n_cmp++;
        if (all_outs !== '0) begin n_fail++; $display("[TB] FAIL reset_outs got=%h exp=0", all_outs); end
        @(negedge clk);
        n_cmp++;
        if (all_outs !== '0) begin n_fail++; $display("[TB] FAIL reset_outs_held got=%h exp=0", all_outs); end
        rstn = 1;
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_fetch();
        if_req = 1; if_addr = 32'h0000_0010; forced_rdata = 32'h0051_3093;
        #1;
        n_cmp++;
        if ({if_gnt, dm_gnt, mem_en, mem_we} !== 4'b1010) begin
            n_fail++; $display("[TB] FAIL fetch_gnt got=%b exp=1010", {if_gnt, dm_gnt, mem_en, mem_we}); end
        n_cmp++;
        if (mem_addr !== 14'h004 || mem_be !== 4'b1111) begin
            n_fail++; $display("[TB] FAIL fetch_mem got addr=%h be=%b exp addr=004 be=1111", mem_addr, mem_be); end
        @(negedge clk);
        n_cmp++;
        if ({if_rvalid, if_err, dm_rvalid} !== 3'b100 || if_rdata !== 32'h0051_3093) begin
            n_fail++; $display("[TB] FAIL fetch_rsp got v/e/dv=%b data=%h exp 100 00513093",
                               {if_rvalid, if_err, dm_rvalid}, if_rdata); end
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_byte_load(input logic uns, input logic [31:0] expv);
        dm_req = 1; dm_we = 0; dm_addr = 32'h4003; dm_n_bytes = 2'b01; dm_unsigned = uns;
        forced_rdata = 32'h80FF_0000;
        #1;
        n_cmp++;
        if ({dm_gnt, if_gnt, mem_en} !== 3'b101 || mem_be !== 4'b1000 || mem_addr !== 14'h1000) begin
            n_fail++; $display("[TB] FAIL byte_load_req got g/ig/en=%b be=%b addr=%h exp 101 1000 1000",
                               {dm_gnt, if_gnt, mem_en}, mem_be, mem_addr); end
        @(negedge clk);
        n_cmp++;
        if ({dm_rvalid, dm_err} !== 2'b10 || dm_rdata !== expv) begin
            n_fail++; $display("[TB] FAIL byte_load_rsp uns=%0d got v/e=%b data=%h exp 10 %h",
                               uns, {dm_rvalid, dm_err}, dm_rdata, expv); end
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_half_store();
        dm_req = 1; dm_we = 1; dm_addr = 32'h4002; dm_n_bytes = 2'b10; dm_wdata = 32'h0000_BEEF;
        forced_rdata = 32'hFFFF_FFFF;
        #1;
        n_cmp++;
        if ({mem_en, mem_we} !== 2'b11 || mem_be !== 4'b1100 || mem_wdata !== 32'hBEEF_BEEF) begin
            n_fail++; $display("[TB] FAIL half_store_req got en/we=%b be=%b wdata=%h exp 11 1100 beefbeef",
                               {mem_en, mem_we}, mem_be, mem_wdata); end
        @(negedge clk);
        n_cmp++;
        if ({dm_rvalid, dm_err} !== 2'b10 || dm_rdata !== 32'h0) begin
            n_fail++; $display("[TB] FAIL half_store_ack got v/e=%b data=%h exp 10 0",
                               {dm_rvalid, dm_err}, dm_rdata); end
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_starvation();
        int  losses;
        bit  exp_if;
        do_reset();
        losses = 0;
        for (int i = 0; i < 15; i++) begin
            if_req = 1; if_addr = 32'h100; dm_req = 1; dm_we = 0; dm_addr = 32'h4000; dm_n_bytes = 2'b00;
            forced_rdata = 32'hA500_0000 | i;
            exp_if = (losses == STARVE_MAX);
            #1;
            n_cmp++;
            if (if_gnt !== exp_if || dm_gnt !== !exp_if) begin
                n_fail++; $display("[TB] FAIL starve_gnt cyc=%0d got if=%b dm=%b exp if=%b", i, if_gnt, dm_gnt, exp_if); end
            losses = exp_if ? 0 : losses + 1;
            @(negedge clk);
            n_cmp++;
            if (if_rvalid !== exp_if || dm_rvalid !== !exp_if ||
                (exp_if ? if_rdata : dm_rdata) !== (32'hA500_0000 | i)) begin
                n_fail++; $display("[TB] FAIL starve_rsp cyc=%0d got iv=%b dv=%b id=%h dd=%h exp if=%b", i,
                                   if_rvalid, dm_rvalid, if_rdata, dm_rdata, exp_if); end
        end
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_errors();
        logic        port_dm [5] = '{1, 1, 0, 1, 1};
        logic        we      [5] = '{0, 1, 0, 0, 0};
        logic [31:0] addr    [5] = '{32'h4001, 32'h0100, 32'h4000, 32'h1_0000, 32'h4000};
        logic [1:0]  nb      [5] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b11};
        for (int c = 0; c < 5; c++) begin
            forced_rdata = 32'hDEAD_BEEF;
            if (port_dm[c]) begin
                dm_req = 1; dm_we = we[c]; dm_addr = addr[c]; dm_n_bytes = nb[c]; dm_wdata = 32'h1234_5678;
            end else begin
                if_req = 1; if_addr = addr[c];
            end
            #1;
            n_cmp++;
            if ((port_dm[c] ? dm_gnt : if_gnt) !== 1'b1 || mem_en !== 1'b0 || mem_we !== 1'b0) begin
                n_fail++; $display("[TB] FAIL err_req case=%0d got gnt=%b/%b en=%b we=%b exp gnt=1 en=0 we=0",
                                   c, if_gnt, dm_gnt, mem_en, mem_we); end
            @(negedge clk);
            n_cmp++;
            if (port_dm[c] ? ({dm_rvalid, dm_err} !== 2'b11 || dm_rdata !== 32'h0)
                           : ({if_rvalid, if_err} !== 2'b11 || if_rdata !== 32'h0)) begin
                n_fail++; $display("[TB] FAIL err_rsp case=%0d got if v/e=%b d=%h dm v/e=%b d=%h exp 11 0",
                                   c, {if_rvalid, if_err}, if_rdata, {dm_rvalid, dm_err}, dm_rdata); end
            drive_idle();
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        dm_req = 1; dm_we = 0; dm_addr = 32'h4004; dm_n_bytes = 2'b00; forced_rdata = 32'h7777_7777;
        #1;
        n_cmp++;
        if (dm_gnt !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_gnt got=%b exp=1", dm_gnt); end
        @(posedge clk);
        #1;
        rstn = 0;
        drive_idle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if (all_outs !== '0) begin n_fail++; $display("[TB] FAIL midrst_outs cyc=%0d got=%h exp=0", i, all_outs); end
        end
        rstn = 1;
        @(negedge clk);
        n_cmp++;
        if (dm_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_stale got=%b exp=0", dm_rvalid); end
        if_req = 1; if_addr = 32'h20; forced_rdata = 32'hCAFE_F00D;
        #1;
        n_cmp++;
        if ({if_gnt, mem_en} !== 2'b11 || mem_addr !== 14'h008) begin
            n_fail++; $display("[TB] FAIL postrst_req got g/en=%b addr=%h exp 11 008", {if_gnt, mem_en}, mem_addr); end
        @(negedge clk);
        n_cmp++;
        if ({if_rvalid, if_err} !== 2'b10 || if_rdata !== 32'hCAFE_F00D) begin
            n_fail++; $display("[TB] FAIL postrst_rsp got v/e=%b data=%h exp 10 cafef00d", {if_rvalid, if_err}, if_rdata); end
        drive_idle();
        @(negedge clk);
    endtask

    function automatic logic dm_req_bad(input logic [31:0] a, input logic [1:0] n, input logic w);
        if (a >= 32'h1_0000 || n == 2'b11) return 1;
        if (n == 2'b00 && a[1:0] != 0) return 1;
        if (n == 2'b10 && a[0]) return 1;
        if (w && a < 32'h4000) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] n, input logic u);
        logic [31:0] w;
        logic [15:0] h;
        logic [7:0]  b;
        w = ref_mem[a[15:2]];
        b = w[8*a[1:0] +: 8];
        h = w[8*a[1:0] +: 16];
        if (n == 2'b01) return u ? {24'h0, b} : {{24{b[7]}}, b};
        if (n == 2'b10) return u ? {16'h0, h} : {{16{h[15]}}, h};
        return w;
    endfunction

    function automatic logic [31:0] rand_dm_addr(input logic [1:0] n);
        int r;
        logic [31:0] a;
        r = $urandom_range(0, 19);
        if (r == 0) return 32'h1_0000 + $urandom_range(0, 255);
        if (r == 1) return $urandom_range(0, 63);
        if (r == 2) return 32'h4000 + $urandom_range(0, 63);
        a = 32'h4000 + $urandom_range(0, 63);
        if (n == 2'b00) a[1:0] = 2'b00;
        if (n == 2'b10) a[0] = 1'b0;
        return a;
    endfunction

    task automatic test_random_traffic();
        bit          if_pend, dm_pend, win_if, win_dm, e_err;
        int          losses;
        logic [31:0] e_data;
        do_reset();
        init_mem = 1;
        for (int i = 0; i < 16384; i++) ref_mem[i] = seed_word(i);
        @(negedge clk);
        init_mem = 0;
        use_model = 1;
        if_pend = 0; dm_pend = 0; losses = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!if_pend && $urandom_range(0, 3) != 0) begin
                if_pend = 1;
                if_addr = ($urandom_range(0, 15) == 0) ? 32'h4000 + $urandom_range(0, 63)
                                                        : $urandom_range(0, 63) & ~32'h3;
                if ($urandom_range(0, 15) == 0) if_addr[1:0] = 2'b10;
            end
            if (!dm_pend && $urandom_range(0, 3) != 0) begin
                dm_pend = 1;
                dm_n_bytes = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                dm_we = 1'($urandom_range(0, 1));
                dm_addr = rand_dm_addr(dm_n_bytes);
                dm_wdata = $urandom;
                dm_unsigned = 1'($urandom_range(0, 1));
            end
            if_req = if_pend;
            dm_req = dm_pend;
            win_if = if_pend && (!dm_pend || losses == STARVE_MAX);
            win_dm = dm_pend && !win_if;
            e_err = 0; e_data = 0;
            if (win_if) begin
                e_err = (if_addr >= 32'h4000) || (if_addr[1:0] != 0);
                e_data = e_err ? 32'h0 : ref_mem[if_addr[15:2]];
            end else if (win_dm) begin
                e_err = dm_req_bad(dm_addr, dm_n_bytes, dm_we);
                e_data = (e_err || dm_we) ? 32'h0 : ref_load(dm_addr, dm_n_bytes, dm_unsigned);
            end
            #1;
            n_cmp++;
            if (if_gnt !== win_if || dm_gnt !== win_dm || mem_en !== ((win_if || win_dm) && !e_err)) begin
                n_fail++; $display("[TB] FAIL rand_gnt cyc=%0d got if=%b dm=%b en=%b exp if=%b dm=%b err=%b",
                                   cyc, if_gnt, dm_gnt, mem_en, win_if, win_dm, e_err); end
            @(posedge clk);
            if (win_dm && dm_we && !e_err) begin
                if (dm_n_bytes == 2'b01)      ref_mem[dm_addr[15:2]][8*dm_addr[1:0] +: 8]  = dm_wdata[7:0];
                else if (dm_n_bytes == 2'b10) ref_mem[dm_addr[15:2]][8*dm_addr[1:0] +: 16] = dm_wdata[15:0];
                else                          ref_mem[dm_addr[15:2]] = dm_wdata;
            end
            if (win_if) losses = 0;
            else if (if_pend && win_dm && losses < STARVE_MAX) losses++;
            if (win_if) if_pend = 0;
            if (win_dm) dm_pend = 0;
            @(negedge clk);
            n_cmp++;
            if (if_rvalid !== win_if || dm_rvalid !== win_dm ||
                (win_if && (if_rdata !== e_data || if_err !== e_err)) ||
                (win_dm && (dm_rdata !== e_data || dm_err !== e_err))) begin
                n_fail++; $display("[TB] FAIL rand_rsp cyc=%0d got iv=%b dv=%b id=%h dd=%h ie=%b de=%b exp data=%h err=%b",
                                   cyc, if_rvalid, dm_rvalid, if_rdata, dm_rdata, if_err, dm_err, e_data, e_err); end
        end
        drive_idle();
        use_model = 0;
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        use_model = 0; init_mem = 0; forced_rdata = 0;
        rstn = 0;
        drive_idle();
        @(negedge clk);
        test_reset();
        test_fetch();
        test_byte_load(1'b0, 32'hFFFF_FF80);
        test_byte_load(1'b1, 32'h0000_0080);
        test_half_store();
        test_starvation();
        test_errors();
        test_reset_mid();
        test_random_traffic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
